tl_tag_table: RTL and testbench

- Outstanding non-posted request tracker for the TL.
- The TX request path allocates a tag and stores the request metadata (req_id, addr, len, attr).
- The completion engine looks up that metadata by tag, combinationally, and frees the tag after the last completion beat is delivered.
- Per-entry completion timeout reclaims tags whose completions never arrive and reports them upstream.

---
 rtl/tl_tag_table.sv | 222 ++++++++++++++++++++++
 tb/tb_tl_tag_table.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_tag_table.sv
// -----------------------------------------------------------------------------
// tl_tag_table
//   Outstanding non-posted request tracker. The TX request path allocates the
//   lowest free tag and stores the request metadata with it. The completion
//   engine reads that metadata back combinationally by tag, then releases the
//   tag once the last completion beat has gone out. Each live entry ages by
//   one per cycle. An entry that reaches TIMEOUT_CYCLES is reclaimed and
//   reported upstream, at most one entry per cycle.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   alloc_valid_i / alloc_ready_o allocation handshake (ready = table not full)
//   alloc_tag_o                   lowest free tag (combinational)
//   alloc_req_id_i/addr/len/attr  metadata captured on the alloc handshake
//   lookup_tag_i / lookup_valid_i lookup request (valid is qualification only)
//   lookup_ready_o                always 1
//   lookup_hit_o, lookup_*_o      hit flag and stored metadata (0 on miss)
//   free_tag_i / free_valid_i     tag release
//   tmo_valid_o / tmo_tag_o       registered pulse: entry timed out, released
//   err_free_o                    registered pulse: illegal free
//   outstanding_o, full_o, empty_o  occupancy
// -----------------------------------------------------------------------------
module tl_tag_table #(
   parameter int unsigned TAG_W          = 8,
   parameter int unsigned NUM_TAGS       = 32,
   parameter int unsigned TMO_W          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   localparam int unsigned CNT_W         = $clog2(NUM_TAGS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_valid_i,
   output logic             alloc_ready_o,
   output logic [TAG_W-1:0] alloc_tag_o,
   input  logic [15:0]      alloc_req_id_i,
   input  logic [31:0]      alloc_addr_i,
   input  logic [9:0]       alloc_len_i,
   input  logic [2:0]       alloc_attr_i,
   input  logic [TAG_W-1:0] lookup_tag_i,
   input  logic             lookup_valid_i,
   output logic             lookup_ready_o,
   output logic             lookup_hit_o,
   output logic [15:0]      lookup_req_id_o,
   output logic [31:0]      lookup_addr_o,
   output logic [9:0]       lookup_len_o,
   output logic [2:0]       lookup_attr_o,
   input  logic [TAG_W-1:0] free_tag_i,
   input  logic             free_valid_i,
   output logic             tmo_valid_o,
   output logic [TAG_W-1:0] tmo_tag_o,
   output logic             err_free_o,
   output logic [CNT_W-1:0] outstanding_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES);

   // Registered state
   logic [NUM_TAGS-1:0] r_valid;
   logic [TMO_W-1:0]    r_age    [NUM_TAGS];
   logic [15:0]         r_req_id [NUM_TAGS];
   logic [31:0]         r_addr   [NUM_TAGS];
   logic [9:0]          r_len    [NUM_TAGS];
   logic [2:0]          r_attr   [NUM_TAGS];
   logic [CNT_W-1:0]    r_count;
   logic                r_tmo_valid;
   logic [TAG_W-1:0]    r_tmo_tag;
   logic                r_err_free;

   // Combinational decode
   logic                w_full;
   logic                w_alloc_found;
   logic [TAG_W-1:0]    w_alloc_idx;
   logic                w_alloc_fire;
   logic [NUM_TAGS-1:0] w_alloc_oh;
   logic                w_free_hit;
   logic                w_free_fire;
   logic [NUM_TAGS-1:0] w_free_oh;
   logic                w_tmo_fire;
   logic [TAG_W-1:0]    w_tmo_idx;
   logic [NUM_TAGS-1:0] w_tmo_oh;
   logic [CNT_W-1:0]    w_count_nxt;
   logic                w_lk_hit;
   logic [15:0]         w_lk_req_id;
   logic [31:0]         w_lk_addr;
   logic [9:0]          w_lk_len;
   logic [2:0]          w_lk_attr;
   logic                w_unused;

   // lookup_valid_i only qualifies the lookup for the consumer; no state uses it
   assign w_unused = lookup_valid_i;

   assign w_full       = (r_count == CNT_W'(NUM_TAGS));
   assign w_alloc_fire = alloc_valid_i && !w_full;

   // Lowest free entry, from registered valid bits only, so a tag freed this
   // cycle is not offered until the next one.
   always_comb begin
      w_alloc_found = 1'b0;
      w_alloc_idx   = '0;
      w_alloc_oh    = '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
         if (!r_valid[i] && !w_alloc_found) begin
            w_alloc_found = 1'b1;
            w_alloc_idx   = TAG_W'(i);
            w_alloc_oh[i] = w_alloc_fire;
         end
      end
   end

   // Legal free: in range and currently allocated. Out-of-range tags match no
   // entry, so they fall out as illegal without a separate bound check.
   always_comb begin
      w_free_hit = 1'b0;
      w_free_oh  = '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
         if (free_tag_i == TAG_W'(i) && r_valid[i]) begin
            w_free_hit   = 1'b1;
            w_free_oh[i] = free_valid_i;
         end
      end
   end
   assign w_free_fire = free_valid_i && w_free_hit;

   // Lowest saturated entry is reclaimed; an entry being freed this cycle is
   // skipped so the free wins and the next candidate can still go.
   always_comb begin
      w_tmo_fire = 1'b0;
      w_tmo_idx  = '0;
      w_tmo_oh   = '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
         if (r_valid[i] && (r_age[i] == TMO_LIM) && !w_free_oh[i] && !w_tmo_fire) begin
            w_tmo_fire  = 1'b1;
            w_tmo_idx   = TAG_W'(i);
            w_tmo_oh[i] = 1'b1;
         end
      end
   end

   // Net occupancy change; alloc only when not full and frees/timeouts only
   // on live entries, so this cannot wrap.
   assign w_count_nxt = r_count + CNT_W'(w_alloc_fire)
                                - CNT_W'(w_free_fire)
                                - CNT_W'(w_tmo_fire);

   always_comb begin
      w_lk_hit    = 1'b0;
      w_lk_req_id = '0;
      w_lk_addr   = '0;
      w_lk_len    = '0;
      w_lk_attr   = '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
         if (lookup_tag_i == TAG_W'(i) && r_valid[i]) begin
            w_lk_hit    = 1'b1;
            w_lk_req_id = r_req_id[i];
            w_lk_addr   = r_addr[i];
            w_lk_len    = r_len[i];
            w_lk_attr   = r_attr[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= '0;
         for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            r_age[i] <= '0;
         end
         r_count     <= '0;
         r_tmo_valid <= 1'b0;
         r_tmo_tag   <= '0;
         r_err_free  <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (w_alloc_oh[i]) begin
               r_valid[i] <= 1'b1;
               r_age[i]   <= '0;
            end else if (w_free_oh[i] || w_tmo_oh[i]) begin
               r_valid[i] <= 1'b0;
               r_age[i]   <= '0;
            end else if (r_valid[i] && (r_age[i] != TMO_LIM)) begin
               r_age[i]   <= r_age[i] + TMO_W'(1);
            end
         end
         r_count     <= w_count_nxt;
         r_tmo_valid <= w_tmo_fire;
         if (w_tmo_fire) begin
            r_tmo_tag <= w_tmo_idx;
         end
         r_err_free  <= free_valid_i && !w_free_hit;
      end
   end

   // Metadata storage has no reset; it is only visible through a valid hit.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
         if (w_alloc_oh[i]) begin
            r_req_id[i] <= alloc_req_id_i;
            r_addr[i]   <= alloc_addr_i;
            r_len[i]    <= alloc_len_i;
            r_attr[i]   <= alloc_attr_i;
         end
      end
   end

   assign alloc_ready_o   = !w_full;
   assign alloc_tag_o     = w_alloc_idx;
   assign lookup_ready_o  = 1'b1;
   assign lookup_hit_o    = w_lk_hit;
   assign lookup_req_id_o = w_lk_req_id;
   assign lookup_addr_o   = w_lk_addr;
   assign lookup_len_o    = w_lk_len;
   assign lookup_attr_o   = w_lk_attr;
   assign tmo_valid_o     = r_tmo_valid;
   assign tmo_tag_o       = r_tmo_tag;
   assign err_free_o      = r_err_free;
   assign outstanding_o   = r_count;
   assign full_o          = w_full;
   assign empty_o         = (r_count == '0);

endmodule

// File: tb/tb_tl_tag_table.sv
// -----------------------------------------------------------------------------
// tb_tl_tag_table
//   Directed bench. Instance A keeps the long default timeout and covers
//   allocation, lookup, free and fill behaviour. Instance B shares every input
//   but uses a 10-cycle timeout, and its outputs are checked only in the
//   timeout and reset steps.
// -----------------------------------------------------------------------------
module tb_tl_tag_table;

   localparam int unsigned TAG_W = 8;
   localparam int unsigned CNT_W = 6;

   logic             clk;
   logic             rst_n;
   logic             alloc_valid;
   logic [15:0]      alloc_req_id;
   logic [31:0]      alloc_addr;
   logic [9:0]       alloc_len;
   logic [2:0]       alloc_attr;
   logic [TAG_W-1:0] lookup_tag;
   logic             lookup_valid;
   logic [TAG_W-1:0] free_tag;
   logic             free_valid;

   logic             a_alloc_ready, b_alloc_ready;
   logic [TAG_W-1:0] a_alloc_tag,   b_alloc_tag;
   logic             a_lookup_ready, b_lookup_ready;
   logic             a_hit,         b_hit;
   logic [15:0]      a_req_id,      b_req_id;
   logic [31:0]      a_addr,        b_addr;
   logic [9:0]       a_len,         b_len;
   logic [2:0]       a_attr,        b_attr;
   logic             a_tmo_valid,   b_tmo_valid;
   logic [TAG_W-1:0] a_tmo_tag,     b_tmo_tag;
   logic             a_err,         b_err;
   logic [CNT_W-1:0] a_out,         b_out;
   logic             a_full,        b_full;
   logic             a_empty,       b_empty;

   int n_checks = 0;
   int n_fail   = 0;

   tl_tag_table #(.TAG_W(8), .NUM_TAGS(32), .TMO_W(16), .TIMEOUT_CYCLES(50000)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid_i(alloc_valid), .alloc_ready_o(a_alloc_ready), .alloc_tag_o(a_alloc_tag),
      .alloc_req_id_i(alloc_req_id), .alloc_addr_i(alloc_addr),
      .alloc_len_i(alloc_len), .alloc_attr_i(alloc_attr),
      .lookup_tag_i(lookup_tag), .lookup_valid_i(lookup_valid), .lookup_ready_o(a_lookup_ready),
      .lookup_hit_o(a_hit), .lookup_req_id_o(a_req_id), .lookup_addr_o(a_addr),
      .lookup_len_o(a_len), .lookup_attr_o(a_attr),
      .free_tag_i(free_tag), .free_valid_i(free_valid),
      .tmo_valid_o(a_tmo_valid), .tmo_tag_o(a_tmo_tag), .err_free_o(a_err),
      .outstanding_o(a_out), .full_o(a_full), .empty_o(a_empty)
   );

   tl_tag_table #(.TAG_W(8), .NUM_TAGS(32), .TMO_W(16), .TIMEOUT_CYCLES(10)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid_i(alloc_valid), .alloc_ready_o(b_alloc_ready), .alloc_tag_o(b_alloc_tag),
      .alloc_req_id_i(alloc_req_id), .alloc_addr_i(alloc_addr),
      .alloc_len_i(alloc_len), .alloc_attr_i(alloc_attr),
      .lookup_tag_i(lookup_tag), .lookup_valid_i(lookup_valid), .lookup_ready_o(b_lookup_ready),
      .lookup_hit_o(b_hit), .lookup_req_id_o(b_req_id), .lookup_addr_o(b_addr),
      .lookup_len_o(b_len), .lookup_attr_o(b_attr),
      .free_tag_i(free_tag), .free_valid_i(free_valid),
      .tmo_valid_o(b_tmo_valid), .tmo_tag_o(b_tmo_tag), .err_free_o(b_err),
      .outstanding_o(b_out), .full_o(b_full), .empty_o(b_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; registered outputs are then stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b1;
      alloc_valid  = 1'b0;
      alloc_req_id = 16'h0100;
      alloc_addr   = '0;
      alloc_len    = 10'd4;
      alloc_attr   = 3'd0;
      lookup_tag   = '0;
      lookup_valid = 1'b0;
      free_tag     = '0;
      free_valid   = 1'b0;
      #1 rst_n = 1'b0;
      #2;

      // ---------------- reset state
      chk("rst_empty",   64'(a_empty),       64'd1);
      chk("rst_full",    64'(a_full),        64'd0);
      chk("rst_ready",   64'(a_alloc_ready), 64'd1);
      chk("rst_tag",     64'(a_alloc_tag),   64'd0);
      chk("rst_hit",     64'(a_hit),         64'd0);
      chk("rst_out",     64'(a_out),         64'd0);
      chk("rst_tmo",     64'(a_tmo_valid),   64'd0);
      chk("rst_tmo_tag", 64'(a_tmo_tag),     64'd0);
      chk("rst_err",     64'(a_err),         64'd0);
      chk("lk_ready",    64'(a_lookup_ready), 64'd1);
      #4 rst_n = 1'b1;

      // ---------------- three allocations, tags 0,1,2
      alloc_valid = 1'b1;
      alloc_addr  = 32'h1000;
      #1 chk("alloc0_tag", 64'(a_alloc_tag), 64'd0);
      tick();
      alloc_addr = 32'h2000;
      #1 chk("alloc1_tag", 64'(a_alloc_tag), 64'd1);
      tick();
      alloc_addr = 32'h3000;
      lookup_tag = 8'd2;
      lookup_valid = 1'b1;
      #1 chk("alloc2_tag", 64'(a_alloc_tag), 64'd2);
      chk("lk2_before", 64'(a_hit), 64'd0);
      tick();
      alloc_valid = 1'b0;
      #1 chk("lk2_after", 64'(a_hit), 64'd1);
      chk("out3", 64'(a_out), 64'd3);
      lookup_tag = 8'd1;
      #1 chk("lk1_hit",  64'(a_hit),    64'd1);
      chk("lk1_addr",    64'(a_addr),   64'h2000);
      chk("lk1_len",     64'(a_len),    64'd4);
      chk("lk1_req_id",  64'(a_req_id), 64'h0100);

      // ---------------- fill table
      for (int i = 0; i < 29; i++) begin
         alloc_valid = 1'b1;
         alloc_addr  = 32'(i);
         #1 chk("fill_tag", 64'(a_alloc_tag), 64'(i + 3));
         tick();
      end
      chk("full_out",   64'(a_out),         64'd32);
      chk("full_flag",  64'(a_full),        64'd1);
      chk("full_ready", 64'(a_alloc_ready), 64'd0);
      chk("full_empty", 64'(a_empty),       64'd0);
      tick();
      chk("full_hold_out", 64'(a_out),         64'd32);
      chk("full_hold_rdy", 64'(a_alloc_ready), 64'd0);
      free_valid = 1'b1;
      free_tag   = 8'd5;
      #1 chk("free5_rdy_same", 64'(a_alloc_ready), 64'd0);
      tick();
      free_valid = 1'b0;
      alloc_addr = 32'hABCD0005;
      #1 chk("free5_out",   64'(a_out),         64'd31);
      chk("free5_ready",    64'(a_alloc_ready), 64'd1);
      chk("free5_tag",      64'(a_alloc_tag),   64'd5);
      chk("free5_full",     64'(a_full),        64'd0);
      tick();
      alloc_valid = 1'b0;
      lookup_tag  = 8'd5;
      #1 chk("realloc5_out", 64'(a_out),  64'd32);
      chk("realloc5_full",   64'(a_full), 64'd1);
      chk("realloc5_addr",   64'(a_addr), 64'hABCD0005);

      // ---------------- reset mid-operation, then same-cycle alloc+free
      rst_n = 1'b0;
      #1 chk("midrst_out", 64'(a_out),       64'd0);
      chk("midrst_tag",    64'(a_alloc_tag), 64'd0);
      chk("midrst_hit",    64'(a_hit),       64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alloc_valid = 1'b1;
         alloc_addr  = 32'h4000 + 32'(i);
         tick();
      end
      free_valid = 1'b1;
      free_tag   = 8'd0;
      #1 chk("af_tag", 64'(a_alloc_tag), 64'd4);
      tick();
      alloc_valid = 1'b0;
      free_valid  = 1'b0;
      lookup_tag  = 8'd4;
      #1 chk("af_out",   64'(a_out),       64'd4);
      chk("af_next_tag", 64'(a_alloc_tag), 64'd0);
      chk("af_lk4",      64'(a_hit),       64'd1);
      lookup_tag = 8'd0;
      #1 chk("af_lk0", 64'(a_hit), 64'd0);

      // ---------------- illegal frees
      free_valid = 1'b1;
      free_tag   = 8'd7;
      tick();
      free_valid = 1'b0;
      chk("err7",     64'(a_err), 64'd1);
      chk("err7_out", 64'(a_out), 64'd4);
      tick();
      chk("err7_end", 64'(a_err), 64'd0);
      free_valid = 1'b1;
      free_tag   = 8'd40;
      tick();
      free_valid = 1'b0;
      chk("err40",     64'(a_err), 64'd1);
      chk("err40_out", 64'(a_out), 64'd4);
      tick();
      chk("err40_end", 64'(a_err), 64'd0);
      lookup_tag = 8'd7;
      #1 chk("lk7_hit", 64'(a_hit),    64'd0);
      chk("lk7_addr",   64'(a_addr),   64'd0);
      chk("lk7_len",    64'(a_len),    64'd0);
      chk("lk7_req_id", 64'(a_req_id), 64'd0);
      lookup_tag = 8'd40;
      #1 chk("lk40_hit", 64'(a_hit), 64'd0);
      free_valid = 1'b1;
      free_tag   = 8'd1;
      tick();
      free_valid = 1'b0;
      chk("legal_free_err", 64'(a_err), 64'd0);
      chk("legal_free_out", 64'(a_out), 64'd3);

      // ---------------- timeout ordering (instance B, 10-cycle timeout)
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      alloc_valid = 1'b1;
      tick();
      tick();
      alloc_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("tmo_pre_valid", 64'(b_tmo_valid), 64'd0);
      chk("tmo_pre_out",   64'(b_out),       64'd2);
      tick();
      chk("tmo0_valid", 64'(b_tmo_valid), 64'd1);
      chk("tmo0_tag",   64'(b_tmo_tag),   64'd0);
      chk("tmo0_out",   64'(b_out),       64'd1);
      tick();
      chk("tmo1_valid", 64'(b_tmo_valid), 64'd1);
      chk("tmo1_tag",   64'(b_tmo_tag),   64'd1);
      chk("tmo1_out",   64'(b_out),       64'd0);
      chk("tmo1_empty", 64'(b_empty),     64'd1);
      tick();
      chk("tmo_end", 64'(b_tmo_valid), 64'd0);

      // ---------------- free wins over timeout in the same cycle
      alloc_valid = 1'b1;
      tick();
      tick();
      alloc_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("fw_pre_out", 64'(b_out), 64'd2);
      free_valid = 1'b1;
      free_tag   = 8'd0;
      tick();
      free_valid = 1'b0;
      chk("fw_tmo",  64'(b_tmo_valid), 64'd0);
      chk("fw_err",  64'(b_err),       64'd0);
      chk("fw_out",  64'(b_out),       64'd1);
      tick();
      chk("fw_next_tmo", 64'(b_tmo_valid), 64'd1);
      chk("fw_next_tag", 64'(b_tmo_tag),   64'd1);
      chk("fw_next_out", 64'(b_out),       64'd0);

      // ---------------- asynchronous reset with five entries live
      alloc_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      alloc_valid = 1'b0;
      lookup_tag  = 8'd2;
      #1 chk("pre_rst_out", 64'(b_out), 64'd5);
      chk("pre_rst_hit",    64'(b_hit), 64'd1);
      rst_n = 1'b0;
      #1 chk("arst_out", 64'(b_out),       64'd0);
      chk("arst_tag",    64'(b_alloc_tag), 64'd0);
      chk("arst_empty",  64'(b_empty),     64'd1);
      chk("arst_hit",    64'(b_hit),       64'd0);
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
